// File: rtl/sram_controller.sv
// Two-beat 16-bit asynchronous SRAM controller for the 32-bit MEM stage; ready low freezes the pipeline.
// Optional range checking with a sticky addr_err output is enabled by defining SRAM_ADDR_CHECK_EN.
module sram_controller #(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
`ifdef SRAM_ADDR_CHECK_EN
    output logic               addr_err,
`endif
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    inout  wire  [15:0]        SRAM_DQ,
    output logic               SRAM_WE_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N
);

    localparam int unsigned CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES);
    localparam int unsigned IW = SRAM_AW - 1;

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            write_reg;
    logic [IW-1:0]   index_reg;
    logic [31:0]     wdata_reg;
    logic [31:0]     read_data_reg;
    logic [31:0]     offset;
    logic            req, accept, cap_lo, cap_hi, dq_drive;
    logic [15:0]     dq_out;
    logic            unused_bits;

    assign req    = rd_en | wr_en;
    assign offset = address - 32'(BASE_ADDR);
    // Bits below the word boundary and above the SRAM index are deliberately ignored.
    assign unused_bits = ^{offset[1:0], offset[31:SRAM_AW+1]};

`ifdef SRAM_ADDR_CHECK_EN
    logic addr_bad, err_set, addr_err_reg;
    assign addr_bad = (address < 32'(BASE_ADDR)) || (|offset[31:SRAM_AW+1]);
    assign addr_err = addr_err_reg;
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ready      = 1'b1;
        SRAM_ADDR  = '0;
        SRAM_WE_N  = 1'b1;
        dq_drive   = 1'b0;
        dq_out     = wdata_reg[15:0];
        accept     = 1'b0;
        cap_lo     = 1'b0;
        cap_hi     = 1'b0;
`ifdef SRAM_ADDR_CHECK_EN
        err_set    = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (req) begin
                    ready      = 1'b0;
                    accept     = 1'b1;
                    cnt_next   = '0;
                    state_next = LOW;
`ifdef SRAM_ADDR_CHECK_EN
                    // Out-of-range requests skip the SRAM entirely.
                    if (addr_bad) begin
                        accept     = 1'b0;
                        err_set    = 1'b1;
                        state_next = DONE;
                    end
`endif
                end
            end
            LOW: begin
                ready     = 1'b0;
                SRAM_ADDR = {index_reg, 1'b0};
                SRAM_WE_N = ~write_reg;
                dq_drive  = write_reg;
                if (cnt_reg == CNT_LAST) begin
                    cnt_next   = '0;
                    state_next = HIGH;
                    cap_lo     = ~write_reg;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            HIGH: begin
                ready     = 1'b0;
                SRAM_ADDR = {index_reg, 1'b1};
                SRAM_WE_N = ~write_reg;
                dq_drive  = write_reg;
                dq_out    = wdata_reg[31:16];
                if (cnt_reg == CNT_LAST) begin
                    cnt_next   = '0;
                    state_next = DONE;
                    cap_hi     = ~write_reg;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            write_reg     <= 1'b0;
            index_reg     <= '0;
            wdata_reg     <= '0;
            read_data_reg <= '0;
`ifdef SRAM_ADDR_CHECK_EN
            addr_err_reg  <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                write_reg <= wr_en;
                index_reg <= offset[SRAM_AW:2];
                wdata_reg <= write_data;
            end
            if (cap_lo) read_data_reg[15:0]  <= SRAM_DQ;
            if (cap_hi) read_data_reg[31:16] <= SRAM_DQ;
`ifdef SRAM_ADDR_CHECK_EN
            if (err_set) addr_err_reg <= 1'b1;
`endif
        end
    end

    assign read_data = read_data_reg;
    assign SRAM_DQ   = dq_drive ? dq_out : 16'hzzzz;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: directed vector table, hand-written corner sequences and random traffic
// against a word-level memory model; the SRAM itself is a half-word array behind the DQ bus.
module tb_sram_controller;
    localparam int unsigned BASE = 1024;
    localparam int unsigned W    = 1;
    localparam int unsigned AW   = 18;
    localparam int unsigned LAST = 2 * W + 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    wire  [31:0] read_data;
    wire         ready;
    wire  [AW-1:0] sram_addr;
    wire  [15:0] sram_dq;
    wire         we_n, ce_n, oe_n, ub_n, lb_n;
`ifdef SRAM_ADDR_CHECK_EN
    wire         addr_err;
`endif

    sram_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(W), .SRAM_AW(AW)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
        .write_data(write_data), .read_data(read_data), .ready(ready),
`ifdef SRAM_ADDR_CHECK_EN
        .addr_err(addr_err),
`endif
        .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq), .SRAM_WE_N(we_n), .SRAM_CE_N(ce_n),
        .SRAM_OE_N(oe_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
    );

    always #5 clk = ~clk;

    // Asynchronous SRAM: drives the bus whenever it is not being written.
    logic [15:0] mem [0:(1<<AW)-1];
    assign sram_dq = we_n ? mem[sram_addr] : 16'hzzzz;
    always @(posedge clk) if (!we_n) mem[sram_addr] <= sram_dq;

    int total = 0;
    int bad   = 0;
    logic [31:0] ref_mem [int];
    logic [31:0] ref_rd;

    typedef struct {
        bit          wr;
        bit          rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic int word_idx(input logic [31:0] addr);
        return int'(((addr - BASE) >> 2) % (32'd1 << (AW - 1)));
    endfunction

    // Starts at a negedge; returns at the negedge of the IDLE cycle that follows DONE.
    task automatic do_access(input bit wr, input bit rd, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] exp_rd, input string tag);
        int idx;
        logic [31:0] e_addr;
        bit e_we_n;
        idx = word_idx(addr);
        wr_en = wr; rd_en = rd; address = addr; write_data = wdata;
        for (int k = 0; k <= int'(LAST); k++) begin
            #1;
            if (k == 0 || k == int'(LAST)) e_addr = 0;
            else if (k <= int'(W) + 1)     e_addr = 32'(2 * idx);
            else                           e_addr = 32'(2 * idx + 1);
            e_we_n = !(wr && k >= 1 && k < int'(LAST));
            chk({tag, " ready"}, 32'(ready), 32'(k == int'(LAST)));
            chk({tag, " sram_addr"}, 32'(sram_addr), e_addr);
            chk({tag, " we_n"}, 32'(we_n), 32'(e_we_n));
            if (!e_we_n)
                chk({tag, " dq"}, 32'(sram_dq), (k <= int'(W) + 1) ? 32'(wdata[15:0]) : 32'(wdata[31:16]));
            if (k == int'(LAST)) chk({tag, " read_data"}, read_data, exp_rd);
            @(negedge clk);
            if (k == 0) begin
                wr_en = 1'b0; rd_en = 1'b0;
                address = $urandom; write_data = $urandom;
            end
        end
        $display("%s wr=%0b rd=%0b addr=%0d wdata=%h read_data=%h exp=%h",
                 tag, wr, rd, addr, wdata, read_data, exp_rd);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 32'd1024, 32'h0,        32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b0, 32'd1032, 32'h12345678, 32'hDEADBEEF};
        vecs[3] = '{1'b0, 1'b1, 32'd1032, 32'h0,        32'h12345678};
        vecs[4] = '{1'b1, 1'b1, 32'd1028, 32'hA5A55A5A, 32'h12345678};
        vecs[5] = '{1'b0, 1'b1, 32'd1028, 32'h0,        32'hA5A55A5A};

        repeat (3) @(negedge clk);
        #1;
        chk("reset ready", 32'(ready), 32'd1);
        chk("reset sram_addr", 32'(sram_addr), 32'd0);
        chk("reset we_n", 32'(we_n), 32'd1);
        chk("reset read_data", read_data, 32'd0);
        chk("tie-offs", {28'd0, ce_n, oe_n, ub_n, lb_n}, 32'd0);
`ifdef SRAM_ADDR_CHECK_EN
        chk("reset addr_err", 32'(addr_err), 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        ref_rd = 32'h0;
        for (int i = 0; i < 6; i++) begin
            do_access(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd,
                      $sformatf("vec%0d", i));
            if (vecs[i].wr) ref_mem[word_idx(vecs[i].addr)] = vecs[i].wdata;
            else            ref_rd = vecs[i].exp_rd;
        end

        // Held read request: 5 low, 1 high, 5 low, 1 high.
        rd_en = 1'b1; address = 32'd1024;
        for (int k = 0; k < 12; k++) begin
            #1;
            chk($sformatf("b2b ready k=%0d", k), 32'(ready), 32'(k % 6 == 5));
            if (k % 6 == 5) chk("b2b read_data", read_data, 32'hDEADBEEF);
            @(negedge clk);
        end
        rd_en = 1'b0;
        ref_rd = 32'hDEADBEEF;
        $display("b2b two held reads at 1024 read_data=%h", read_data);

        // Reset during HIGH of a read: low half already captured, then dropped.
        rd_en = 1'b1; address = 32'd1032;
        @(negedge clk); rd_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("abort low half", read_data, 32'hDEAD5678);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("abort ready", 32'(ready), 32'd1);
        chk("abort we_n", 32'(we_n), 32'd1);
        chk("abort sram_addr", 32'(sram_addr), 32'd0);
        chk("abort read_data", read_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("abort not resumed", {31'd0, ready}, 32'd1);
        @(negedge clk);
        $display("abort reset during HIGH read_data=%h", read_data);
        do_access(1'b0, 1'b1, 32'd1032, 32'h0, 32'h12345678, "after_abort");
        ref_rd = 32'h12345678;

`ifndef SRAM_ADDR_CHECK_EN
        // Word index wraps modulo 2^(AW-1).
        do_access(1'b1, 1'b0, BASE + 4 * ((32'd1 << (AW - 1)) + 3), 32'h0BADF00D, ref_rd, "wrap_wr");
        ref_mem[3] = 32'h0BADF00D;
        do_access(1'b0, 1'b1, 32'd1036, 32'h0, 32'h0BADF00D, "wrap_rd");
        ref_rd = 32'h0BADF00D;
`else
        rd_en = 1'b1; address = 32'd1020;
        #1;
        chk("err ready low", 32'(ready), 32'd0);
        @(negedge clk);
        rd_en = 1'b0;
        #1;
        chk("err ready done", 32'(ready), 32'd1);
        chk("err addr_err", 32'(addr_err), 32'd1);
        chk("err we_n", 32'(we_n), 32'd1);
        chk("err sram_addr", 32'(sram_addr), 32'd0);
        chk("err read_data", read_data, ref_rd);
        @(negedge clk);
        $display("err read at 1020 addr_err=%0b", addr_err);
        wr_en = 1'b1; address = BASE + 4 * (32'd1 << (AW - 1)); write_data = 32'h11111111;
        #1;
        chk("err2 ready low", 32'(ready), 32'd0);
        @(negedge clk);
        wr_en = 1'b0;
        #1;
        chk("err2 we_n", 32'(we_n), 32'd1);
        chk("err2 ready", 32'(ready), 32'd1);
        @(negedge clk);
        $display("err write past top addr_err=%0b", addr_err);
        do_access(1'b0, 1'b1, 32'd1024, 32'h0, 32'hDEADBEEF, "err_after");
        ref_rd = 32'hDEADBEEF;
        chk("err sticky", 32'(addr_err), 32'd1);
`endif

        // Random traffic against the word-level model.
        for (int n = 0; n < 40; n++) begin
            int idx, op;
            logic [31:0] d, a;
            idx = int'($urandom_range(0, 15));
            op  = int'($urandom_range(0, 2));
            d   = $urandom;
            a   = BASE + 32'(idx) * 4;
            if (op == 0 && !ref_mem.exists(idx)) op = 1;
            if (op == 0) begin
                ref_rd = ref_mem[idx];
                do_access(1'b0, 1'b1, a, d, ref_rd, $sformatf("rnd%0d", n));
            end else begin
                do_access(1'b1, op == 2, a, d, ref_rd, $sformatf("rnd%0d", n));
                ref_mem[idx] = d;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
